// File: rtl/lcd_uart_pkg.sv
// lcd_uart_pkg: shared state type and baud divisor helper for the LCD UART receiver
package lcd_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  localparam int OVERSAMPLE = 16;
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
  endfunction
endpackage

// File: rtl/lcd_byte_fifo.sv
// lcd_byte_fifo: DEPTH x 8 synchronous FIFO whose head entry is always visible
module lcd_byte_fifo import lcd_uart_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic do_pop, do_push;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rptr];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk)
    if (!rst_n) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      rptr <= rptr + AW'(do_pop);
      wptr <= wptr + AW'(do_push);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  // storage is cleared on reset so the head reads zero when idle
  always_ff @(posedge clk)
    if (!rst_n) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (do_push) mem[wptr] <= din;
endmodule

// File: rtl/lcd_uart_rx.sv
// lcd_uart_rx: 16x oversampled 8N1 receiver feeding a byte FIFO on a valid/ready stream
module lcd_uart_rx import lcd_uart_pkg::*; #(
  parameter int CLK_HZ = 10_000_000,
  parameter int BAUD   = 9600,
  parameter int DEPTH  = 8
) (
  input  logic                   SYSCLK,
  input  logic                   NSYSRESET,
  input  logic                   RXD,
  output logic [7:0]             M_DATA,
  output logic                   M_VALID,
  input  logic                   M_READY,
  output logic                   FRAME_ERR,
  output logic                   OVERRUN,
  output logic [$clog2(DEPTH):0] FIFO_COUNT
);
  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int TW = $clog2(DIV + 1);
  localparam int PW = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] MID = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] LAST = PW'(OVERSAMPLE - 1);
  state_t state, state_n;
  logic rx_m, rx_s, tick, push, ferr, full, empty, pop;
  logic [TW-1:0] tcnt;
  logic [PW-1:0] ph, ph_n;
  logic [2:0] bitc, bitc_n;
  logic [7:0] shift, shift_n;
  assign tick = tcnt == TW'(DIV - 1);
  assign M_VALID = !empty;
  assign pop = M_VALID && M_READY;
  // two-flop synchroniser for the asynchronous line, idling high
  always_ff @(posedge SYSCLK)
    if (!NSYSRESET) {rx_m, rx_s} <= 2'b11;
    else {rx_m, rx_s} <= {RXD, rx_m};
  // oversampling tick divider, parked at zero while idle
  always_ff @(posedge SYSCLK)
    if (!NSYSRESET) tcnt <= '0;
    else tcnt <= (state == IDLE || tick) ? '0 : tcnt + 1'b1;
  // state register plus frame datapath and registered flag pulses
  always_ff @(posedge SYSCLK)
    if (!NSYSRESET) begin
      state <= IDLE;
      ph <= '0;
      bitc <= '0;
      shift <= '0;
      FRAME_ERR <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      state <= state_n;
      ph <= ph_n;
      bitc <= bitc_n;
      shift <= shift_n;
      FRAME_ERR <= ferr;
      OVERRUN <= push && full && !pop;
    end
  // next state: mid-bit sampling via the 16-tick phase counter
  always_comb begin
    state_n = state;
    ph_n = tick ? ph + 1'b1 : ph;
    bitc_n = bitc;
    shift_n = shift;
    push = 1'b0;
    ferr = 1'b0;
    case (state)
      IDLE: begin
        ph_n = '0;
        if (!rx_s) state_n = START;
      end
      START: if (tick && ph == MID) begin
        ph_n = '0;
        bitc_n = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (tick && ph == LAST) begin
        shift_n = {rx_s, shift[7:1]};
        bitc_n = bitc + 1'b1;
        if (bitc == 3'd7) state_n = STOP;
      end
      STOP: if (tick && ph == LAST) begin
        push = rx_s;
        ferr = !rx_s;
        state_n = rx_s ? IDLE : BREAK;
      end
      BREAK: if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  lcd_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(SYSCLK),
    .rst_n(NSYSRESET),
    .push(push),
    .din(shift),
    .pop(pop),
    .dout(M_DATA),
    .full(full),
    .empty(empty),
    .count(FIFO_COUNT)
  );
endmodule
